// File: rtl/count_event_monitor.sv
// count_event_monitor
// Watches the up/down counter's controls and flags, classifies each cycle
// as load / wrap_up / wrap_down / nothing, timestamps the event with a
// free-running cycle counter and queues the record in a small FIFO that
// drains through a valid/ready stream.
// Optional build macro: COUNT_EVENT_STATS_EN enables the saturating
// up_wraps / down_wraps statistics counters. When it is undefined, both
// outputs are tied to zero.
module count_event_monitor #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int STAMP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ce,
    input  logic                       up_down,
    input  logic                       load_n,
    input  logic [WIDTH-1:0]           count_in,
    input  logic                       max_count,
    input  logic                       zero,
    input  logic                       clr,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [1:0]                 ev_type,
    output logic [WIDTH-1:0]           ev_count,
    output logic [STAMP_W-1:0]         ev_stamp,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       dropped,
    output logic [7:0]                 up_wraps,
    output logic [7:0]                 down_wraps
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 2 + WIDTH + STAMP_W;

    localparam logic [1:0] EV_LOAD      = 2'd0;
    localparam logic [1:0] EV_WRAP_UP   = 2'd1;
    localparam logic [1:0] EV_WRAP_DOWN = 2'd2;

    localparam logic [STAMP_W-1:0] STAMP_ONE = {{(STAMP_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]        PTR_ONE   = {{AW{1'b0}}, 1'b1};

    logic [STAMP_W-1:0] r_stamp;
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [REC_W-1:0]   r_mem [DEPTH];
    logic               r_dropped;

    logic               w_ev_det;
    logic [1:0]         w_ev_code;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [REC_W-1:0]   w_head;

    // Free-running timestamp; an event records the value before this increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stamp <= {STAMP_W{1'b0}};
        end else begin
            r_stamp <= r_stamp + STAMP_ONE;
        end
    end

    // Classify the sampled counter activity; load overrides both wrap kinds.
    always_comb begin
        w_ev_det  = 1'b0;
        w_ev_code = EV_LOAD;
        if (!load_n) begin
            w_ev_det  = 1'b1;
            w_ev_code = EV_LOAD;
        end else if (ce && up_down && max_count) begin
            w_ev_det  = 1'b1;
            w_ev_code = EV_WRAP_UP;
        end else if (ce && !up_down && zero) begin
            w_ev_det  = 1'b1;
            w_ev_code = EV_WRAP_DOWN;
        end else begin
            w_ev_det  = 1'b0;
            w_ev_code = EV_LOAD;
        end
    end

    // Full when the pointers differ only in the wrap bit.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A full FIFO still takes a record when the head leaves in the same cycle.
    assign w_pop  = !w_empty && ev_ready;
    assign w_push = w_ev_det && (!w_full || w_pop);

    // Record storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {REC_W{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_ev_code, count_in, r_stamp};
        end else begin
            r_mem <= r_mem;
        end
    end

    // Write and read pointers with an extra wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    // Sticky loss flag: a new drop takes precedence over clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dropped <= 1'b0;
        end else if (w_ev_det && !w_push) begin
            r_dropped <= 1'b1;
        end else if (clr) begin
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= r_dropped;
        end
    end

    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign ev_valid   = !w_empty;
    assign ev_type    = w_head[REC_W-1 -: 2];
    assign ev_count   = w_head[STAMP_W +: WIDTH];
    assign ev_stamp   = w_head[STAMP_W-1:0];
    assign fifo_level = r_wr_ptr - r_rd_ptr;
    assign dropped    = r_dropped;

`ifdef COUNT_EVENT_STATS_EN
    logic [7:0] r_up_wraps;
    logic [7:0] r_down_wraps;

    // Saturating wrap statistics; clr overrides a coincident event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_wraps   <= 8'd0;
            r_down_wraps <= 8'd0;
        end else if (clr) begin
            r_up_wraps   <= 8'd0;
            r_down_wraps <= 8'd0;
        end else begin
            if (w_ev_det && (w_ev_code == EV_WRAP_UP) && (r_up_wraps != 8'hFF)) begin
                r_up_wraps <= r_up_wraps + 8'd1;
            end else begin
                r_up_wraps <= r_up_wraps;
            end
            if (w_ev_det && (w_ev_code == EV_WRAP_DOWN) && (r_down_wraps != 8'hFF)) begin
                r_down_wraps <= r_down_wraps + 8'd1;
            end else begin
                r_down_wraps <= r_down_wraps;
            end
        end
    end

    assign up_wraps   = r_up_wraps;
    assign down_wraps = r_down_wraps;
`else
    assign up_wraps   = 8'd0;
    assign down_wraps = 8'd0;
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
// Self-checking bench for count_event_monitor: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_count_event_monitor;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int STAMP_W = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   ce;
    logic                   up_down;
    logic                   load_n;
    logic [WIDTH-1:0]       count_in;
    logic                   max_count;
    logic                   zero;
    logic                   clr;
    logic                   ev_valid;
    logic                   ev_ready;
    logic [1:0]             ev_type;
    logic [WIDTH-1:0]       ev_count;
    logic [STAMP_W-1:0]     ev_stamp;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   dropped;
    logic [7:0]             up_wraps;
    logic [7:0]             down_wraps;

    count_event_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .up_down(up_down), .load_n(load_n),
        .count_in(count_in), .max_count(max_count), .zero(zero), .clr(clr),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
        .ev_count(ev_count), .ev_stamp(ev_stamp), .fifo_level(fifo_level),
        .dropped(dropped), .up_wraps(up_wraps), .down_wraps(down_wraps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int typ;
        int cnt;
        int stamp;
    } rec_t;

    rec_t m_q[$];
    int   m_stamp;
    int   m_dropped;
    int   m_up;
    int   m_dn;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_stamp   = 0;
        m_dropped = 0;
        m_up      = 0;
        m_dn      = 0;
    endtask

    task automatic check_all();
        check_val("ev_valid", int'(ev_valid), (m_q.size() != 0) ? 1 : 0);
        if (m_q.size() != 0) begin
            check_val("ev_type",  int'(ev_type),  m_q[0].typ);
            check_val("ev_count", int'(ev_count), m_q[0].cnt);
            check_val("ev_stamp", int'(ev_stamp), m_q[0].stamp);
        end
        check_val("fifo_level", int'(fifo_level), m_q.size());
        check_val("dropped",    int'(dropped),    m_dropped);
        check_val("up_wraps",   int'(up_wraps),   m_up);
        check_val("down_wraps", int'(down_wraps), m_dn);
    endtask

    // One clock: predict from current inputs, advance the model after the edge, compare.
    task automatic step();
        int   ev;
        bit   pop;
        bit   acc;
        rec_t r;
        ev = -1;
        if (!load_n)                         ev = 0;
        else if (ce && up_down && max_count) ev = 1;
        else if (ce && !up_down && zero)     ev = 2;
        pop = (m_q.size() > 0) && ev_ready;
        acc = (ev >= 0) && ((m_q.size() < DEPTH) || pop);
        r.typ   = ev;
        r.cnt   = int'(count_in);
        r.stamp = m_stamp;
        @(posedge clk);
        #1;
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(r);
        if ((ev >= 0) && !acc) m_dropped = 1;
        else if (clr)          m_dropped = 0;
`ifdef COUNT_EVENT_STATS_EN
        if (clr) begin
            m_up = 0;
            m_dn = 0;
        end else begin
            if (ev == 1 && m_up < 255) m_up++;
            if (ev == 2 && m_dn < 255) m_dn++;
        end
`endif
        m_stamp = (m_stamp + 1) % (1 << STAMP_W);
        check_all();
    endtask

    task automatic idle_inputs();
        ce = 1'b0; up_down = 1'b0; load_n = 1'b1; count_in = '0;
        max_count = 1'b0; zero = 1'b0; clr = 1'b0;
    endtask

    task automatic set_wrap_down();
        idle_inputs();
        ce = 1'b1; up_down = 1'b0; zero = 1'b1;
        count_in = 4'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_valid",   int'(ev_valid),   0);
        check_val("rst_level",   int'(fifo_level), 0);
        check_val("rst_dropped", int'(dropped),    0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        ev_ready = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        check_all();

        // Wrap up at stamp 5 with an empty FIFO.
        ev_ready = 1'b1;
        repeat (5) step();
        idle_inputs();
        ce = 1'b1; up_down = 1'b1; count_in = 4'd15; max_count = 1'b1;
        step();
        check_val("wrapup_type",  int'(ev_type),  1);
        check_val("wrapup_count", int'(ev_count), 15);
        check_val("wrapup_stamp", int'(ev_stamp), 5);
        idle_inputs();
        step();

        // Load beats a simultaneous wrap_down.
        ev_ready = 1'b0;
        idle_inputs();
        load_n = 1'b0; ce = 1'b1; up_down = 1'b0; zero = 1'b1; count_in = 4'd9;
        step();
        check_val("loadpri_level", int'(fifo_level), 1);
        check_val("loadpri_type",  int'(ev_type),    0);
        check_val("loadpri_down",  int'(down_wraps), 0);
        idle_inputs();

        // Three buffered records, then reset mid-stream; stamp restarts at 0.
        load_n = 1'b0; count_in = 4'd3;
        repeat (2) step();
        idle_inputs();
        check_val("pre_rst_level", int'(fifo_level), 3);
        do_reset();
        load_n = 1'b0; count_in = 4'd7;
        step();
        check_val("post_rst_stamp", int'(ev_stamp), 0);
        idle_inputs();
        ev_ready = 1'b1;
        step();

        // Five wrap_downs into a stalled FIFO: four kept, one dropped.
        ev_ready = 1'b0;
        set_wrap_down();
        repeat (5) step();
        idle_inputs();
        check_val("full_level",   int'(fifo_level), 4);
        check_val("full_dropped", int'(dropped),    1);
        step();
        ev_ready = 1'b1;
        repeat (4) step();
        check_val("drained_level", int'(fifo_level), 0);

        // Full FIFO with a pop and a push together.
        clr = 1'b1;
        step();
        ev_ready = 1'b0;
        set_wrap_down();
        repeat (4) step();
        ev_ready = 1'b1;
        count_in = 4'd5;
        step();
        check_val("fullpop_level",   int'(fifo_level), 4);
        check_val("fullpop_dropped", int'(dropped),    0);
        idle_inputs();
        repeat (4) step();

        // 300 wrap_ups with a stalled stream, then clr.
        ev_ready = 1'b0;
        idle_inputs();
        ce = 1'b1; up_down = 1'b1; max_count = 1'b1; count_in = 4'd15;
        repeat (300) step();
`ifdef COUNT_EVENT_STATS_EN
        check_val("stats_sat", int'(up_wraps), 255);
`else
        check_val("stats_off", int'(up_wraps), 0);
`endif
        idle_inputs();
        clr = 1'b1;
        step();
        check_val("clr_up",      int'(up_wraps), 0);
        check_val("clr_dropped", int'(dropped),  0);
        clr = 1'b0;
        ev_ready = 1'b1;
        repeat (4) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            load_n    = ($urandom_range(0, 7) != 0);
            ce        = ($urandom_range(0, 3) != 0);
            up_down   = $urandom_range(0, 1);
            max_count = ($urandom_range(0, 2) == 0);
            zero      = ($urandom_range(0, 2) == 0);
            count_in  = WIDTH'($urandom);
            clr       = ($urandom_range(0, 30) == 0);
            ev_ready  = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
